// File: rtl/rv32_decode_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, ALU op codes,
// immediate select codes and the registered control-word layout.
package rv32_decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [4:0] ALU_LUI     = 5'b00000;
    localparam logic [4:0] ALU_AUIPC   = 5'b00001;
    localparam logic [4:0] ALU_ADD     = 5'b00010;
    localparam logic [4:0] ALU_BEQ     = 5'b00011;
    localparam logic [4:0] ALU_BNE     = 5'b00100;
    localparam logic [4:0] ALU_BLT     = 5'b00101;
    localparam logic [4:0] ALU_BGE     = 5'b00110;
    localparam logic [4:0] ALU_BLTU    = 5'b00111;
    localparam logic [4:0] ALU_BGEU    = 5'b01000;
    localparam logic [4:0] ALU_SLT     = 5'b01001;
    localparam logic [4:0] ALU_SLTU    = 5'b01010;
    localparam logic [4:0] ALU_XOR     = 5'b01011;
    localparam logic [4:0] ALU_OR      = 5'b01100;
    localparam logic [4:0] ALU_AND     = 5'b01101;
    localparam logic [4:0] ALU_SLL     = 5'b01110;
    localparam logic [4:0] ALU_SRL     = 5'b01111;
    localparam logic [4:0] ALU_SRA     = 5'b10000;
    localparam logic [4:0] ALU_SUB     = 5'b10001;
    localparam logic [4:0] ALU_FENCE   = 5'b10010;
    localparam logic [4:0] ALU_ILLEGAL = 5'b11111;

    localparam logic [2:0] IMM_U = 3'b000;
    localparam logic [2:0] IMM_J = 3'b001;
    localparam logic [2:0] IMM_I = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_S = 3'b100;

    typedef struct packed {
        logic [4:0] alu_op;
        logic [2:0] immsel;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic [2:0] mem_size;
        logic       branch;
        logic       jump;
        logic       alu_src_imm;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] imm;
    } word_t;

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational RV32I immediate expander; anything not U/J/B/S is treated as I-type.
module rv32_imm_gen
    import rv32_decode_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [2:0]  immsel_i,
    output logic [31:0] imm_o
);

    always_comb begin
        case (immsel_i)
            IMM_U:   imm_o = {instr_i[31:12], 12'b0};
            IMM_J:   imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            IMM_B:   imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_S:   imm_o = {{21{instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
            default: imm_o = {{21{instr_i[31]}}, instr_i[30:20]};
        endcase
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// Registered RV32I decode stage: full control word + immediate, illegal detection,
// sticky halt on ECALL/EBREAK, optional skid entry to cut the ready path.
module rv32_decode_stage
    import rv32_decode_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter bit SKID_EN  = 1'b1,
    parameter bit FENCE_EN = 1'b1
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_alu_op,
    output logic [2:0]      out_immsel,
    output logic [31:0]     out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_reg_we,
    output logic            out_mem_re,
    output logic            out_mem_we,
    output logic [2:0]      out_mem_size,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_alu_src_imm,
    output logic            out_illegal,
    output logic            halt
);

    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    ctrl_t           dec;
    logic [31:0]     imm;
    logic            is_sys, out_free, accept;
    word_t           out_q, skid_q;
    logic [PC_W-1:0] out_pc_q, skid_pc_q;
    logic            out_valid_q, skid_valid_q, halt_q;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign is_sys = (opcode == OP_SYSTEM);

    always_comb begin
        dec          = '0;
        dec.alu_op   = ALU_ADD;
        dec.immsel   = IMM_I;
        dec.rs1      = in_instr[19:15];
        dec.rs2      = in_instr[24:20];
        dec.rd       = in_instr[11:7];
        dec.mem_size = f3;
        case (opcode)
            OP_LUI:   begin dec.alu_op = ALU_LUI; dec.immsel = IMM_U; dec.reg_we = 1'b1; dec.alu_src_imm = 1'b1; end
            OP_AUIPC: begin dec.alu_op = ALU_AUIPC; dec.immsel = IMM_U; dec.reg_we = 1'b1; dec.alu_src_imm = 1'b1; end
            OP_JAL:   begin dec.immsel = IMM_J; dec.reg_we = 1'b1; dec.jump = 1'b1; dec.alu_src_imm = 1'b1; end
            OP_JALR:  begin dec.reg_we = 1'b1; dec.jump = 1'b1; dec.alu_src_imm = 1'b1; end
            OP_BRANCH: begin
                dec.immsel = IMM_B;
                dec.branch = 1'b1;
                case (f3)
                    3'b000:  dec.alu_op = ALU_BEQ;
                    3'b001:  dec.alu_op = ALU_BNE;
                    3'b100:  dec.alu_op = ALU_BLT;
                    3'b101:  dec.alu_op = ALU_BGE;
                    3'b110:  dec.alu_op = ALU_BLTU;
                    3'b111:  dec.alu_op = ALU_BGEU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec.reg_we = 1'b1; dec.mem_re = 1'b1; dec.alu_src_imm = 1'b1;
                dec.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                dec.immsel = IMM_S; dec.mem_we = 1'b1; dec.alu_src_imm = 1'b1;
                dec.illegal = (f3 >= 3'b011);
            end
            OP_IMM: begin
                dec.reg_we = 1'b1; dec.alu_src_imm = 1'b1;
                case (f3)
                    3'b000: dec.alu_op = ALU_ADD;
                    3'b001: begin dec.alu_op = ALU_SLL; dec.illegal = (f7 != 7'h00); end
                    3'b010: dec.alu_op = ALU_SLT;
                    3'b011: dec.alu_op = ALU_SLTU;
                    3'b100: dec.alu_op = ALU_XOR;
                    3'b101: begin
                        dec.alu_op  = (f7 == 7'h20) ? ALU_SRA : ALU_SRL;
                        dec.illegal = (f7 != 7'h00) && (f7 != 7'h20);
                    end
                    3'b110:  dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            OP_OP: begin
                dec.reg_we = 1'b1;
                case ({f7, f3})
                    {7'h00, 3'b000}: dec.alu_op = ALU_ADD;
                    {7'h20, 3'b000}: dec.alu_op = ALU_SUB;
                    {7'h00, 3'b001}: dec.alu_op = ALU_SLL;
                    {7'h00, 3'b010}: dec.alu_op = ALU_SLT;
                    {7'h00, 3'b011}: dec.alu_op = ALU_SLTU;
                    {7'h00, 3'b100}: dec.alu_op = ALU_XOR;
                    {7'h00, 3'b101}: dec.alu_op = ALU_SRL;
                    {7'h20, 3'b101}: dec.alu_op = ALU_SRA;
                    {7'h00, 3'b110}: dec.alu_op = ALU_OR;
                    {7'h00, 3'b111}: dec.alu_op = ALU_AND;
                    default:         dec.illegal = 1'b1;
                endcase
            end
            OP_FENCE: begin
                if (FENCE_EN) dec.alu_op = ALU_FENCE;
                else          dec.illegal = 1'b1;
            end
            OP_SYSTEM: dec.alu_op = ALU_ADD;
            default:   dec.illegal = 1'b1;
        endcase
        // Illegal words must not have side effects downstream.
        if (dec.illegal) begin
            dec.alu_op      = ALU_ILLEGAL;
            dec.reg_we      = 1'b0;
            dec.mem_re      = 1'b0;
            dec.mem_we      = 1'b0;
            dec.branch      = 1'b0;
            dec.jump        = 1'b0;
            dec.alu_src_imm = 1'b0;
        end
    end

    rv32_imm_gen u_imm (
        .instr_i  (in_instr),
        .immsel_i (dec.immsel),
        .imm_o    (imm)
    );

    assign out_free = !out_valid_q || out_ready;
    // With the skid, in_ready depends only on flops, never on out_ready.
    assign in_ready = !rst && !halt_q && (SKID_EN ? !skid_valid_q : out_free);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_pc_q     <= '0;
            skid_pc_q    <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            if (flush) begin
                out_valid_q  <= 1'b0;
                skid_valid_q <= 1'b0;
            end else if (out_free) begin
                if (skid_valid_q) begin
                    out_q        <= skid_q;
                    out_pc_q     <= skid_pc_q;
                    out_valid_q  <= 1'b1;
                    skid_valid_q <= 1'b0;
                end else if (accept) begin
                    out_q       <= '{ctrl: dec, imm: imm};
                    out_pc_q    <= in_pc;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (accept) begin
                skid_q       <= '{ctrl: dec, imm: imm};
                skid_pc_q    <= in_pc;
                skid_valid_q <= 1'b1;
            end
            if (accept && !flush && is_sys) halt_q <= 1'b1;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_pc          = out_pc_q;
    assign out_alu_op      = out_q.ctrl.alu_op;
    assign out_immsel      = out_q.ctrl.immsel;
    assign out_imm         = out_q.imm;
    assign out_rs1         = out_q.ctrl.rs1;
    assign out_rs2         = out_q.ctrl.rs2;
    assign out_rd          = out_q.ctrl.rd;
    assign out_reg_we      = out_q.ctrl.reg_we;
    assign out_mem_re      = out_q.ctrl.mem_re;
    assign out_mem_we      = out_q.ctrl.mem_we;
    assign out_mem_size    = out_q.ctrl.mem_size;
    assign out_branch      = out_q.ctrl.branch;
    assign out_jump        = out_q.ctrl.jump;
    assign out_alu_src_imm = out_q.ctrl.alu_src_imm;
    assign out_illegal     = out_q.ctrl.illegal;
    assign halt            = halt_q;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: dut 0 has the skid entry, dut 1 does not.
// A queue-level model predicts handshake, ordering and the decoded word.
module tb_rv32_decode_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        t_fl [2], t_iv [2], t_ir [2], t_ord [2], t_ov [2];
    logic        t_we [2], t_re [2], t_mwe [2], t_br [2], t_jmp [2], t_srci [2], t_ill [2], t_hlt [2];
    logic [31:0] t_ins [2], t_ipc [2], t_opc [2], t_imm [2];
    logic [4:0]  t_alu [2], t_rs1 [2], t_rs2 [2], t_rd [2];
    logic [2:0]  t_isel [2], t_msz [2];

    rv32_decode_stage #(.PC_W(32), .SKID_EN(1'b1), .FENCE_EN(1'b1)) u_skid (
        .clk(clk), .rst(rst), .flush(t_fl[0]), .in_valid(t_iv[0]), .in_ready(t_ir[0]),
        .in_instr(t_ins[0]), .in_pc(t_ipc[0]), .out_valid(t_ov[0]), .out_ready(t_ord[0]),
        .out_pc(t_opc[0]), .out_alu_op(t_alu[0]), .out_immsel(t_isel[0]), .out_imm(t_imm[0]),
        .out_rs1(t_rs1[0]), .out_rs2(t_rs2[0]), .out_rd(t_rd[0]), .out_reg_we(t_we[0]),
        .out_mem_re(t_re[0]), .out_mem_we(t_mwe[0]), .out_mem_size(t_msz[0]), .out_branch(t_br[0]),
        .out_jump(t_jmp[0]), .out_alu_src_imm(t_srci[0]), .out_illegal(t_ill[0]), .halt(t_hlt[0]));

    rv32_decode_stage #(.PC_W(32), .SKID_EN(1'b0), .FENCE_EN(1'b1)) u_noskid (
        .clk(clk), .rst(rst), .flush(t_fl[1]), .in_valid(t_iv[1]), .in_ready(t_ir[1]),
        .in_instr(t_ins[1]), .in_pc(t_ipc[1]), .out_valid(t_ov[1]), .out_ready(t_ord[1]),
        .out_pc(t_opc[1]), .out_alu_op(t_alu[1]), .out_immsel(t_isel[1]), .out_imm(t_imm[1]),
        .out_rs1(t_rs1[1]), .out_rs2(t_rs2[1]), .out_rd(t_rd[1]), .out_reg_we(t_we[1]),
        .out_mem_re(t_re[1]), .out_mem_we(t_mwe[1]), .out_mem_size(t_msz[1]), .out_branch(t_br[1]),
        .out_jump(t_jmp[1]), .out_alu_src_imm(t_srci[1]), .out_illegal(t_ill[1]), .halt(t_hlt[1]));

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  alu;
        logic [2:0]  isel;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        we, re, mwe;
        logic [2:0]  msz;
        logic        br, jmp, srci, ill;
    } wd_t;

    typedef struct {
        logic [31:0] x;
        logic [4:0]  alu;
        logic [2:0]  isel;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we, mwe, br, ill, srci, ci;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    wd_t         mh [2][2];
    int          mn [2];
    bit          mhalt [2];
    logic [31:0] seen [$];

    task automatic chk(string nm, int d, logic [127:0] a, logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h", nm, d, a, e);
        end
    endtask

    function automatic wd_t obs(int d);
        wd_t w;
        w.pc = t_opc[d]; w.alu = t_alu[d]; w.isel = t_isel[d]; w.imm = t_imm[d];
        w.rs1 = t_rs1[d]; w.rs2 = t_rs2[d]; w.rd = t_rd[d];
        w.we = t_we[d]; w.re = t_re[d]; w.mwe = t_mwe[d]; w.msz = t_msz[d];
        w.br = t_br[d]; w.jmp = t_jmp[d]; w.srci = t_srci[d]; w.ill = t_ill[d];
        return w;
    endfunction

    // Reference decode from the ISA tables: f3-indexed op tables, immediates by arithmetic.
    function automatic wd_t model(logic [31:0] x, logic [31:0] pc);
        wd_t w;
        bit ok;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [12:0] b13;
        logic [20:0] j21;
        logic [4:0] alu_tbl [8];
        logic [4:0] br_tbl [8];
        alu_tbl = '{5'd2, 5'd14, 5'd9, 5'd10, 5'd11, 5'd15, 5'd12, 5'd13};
        br_tbl  = '{5'd3, 5'd4, 5'd0, 5'd0, 5'd5, 5'd6, 5'd7, 5'd8};
        op = x[6:0]; f3 = x[14:12]; f7 = x[31:25]; ok = 1'b1;
        w = '0; w.pc = pc; w.rs1 = x[19:15]; w.rs2 = x[24:20]; w.rd = x[11:7];
        w.msz = f3; w.isel = 3'd2; w.alu = 5'd2;
        case (op)
            7'h37: begin w.alu = 5'd0; w.isel = 3'd0; w.we = 1; w.srci = 1; end
            7'h17: begin w.alu = 5'd1; w.isel = 3'd0; w.we = 1; w.srci = 1; end
            7'h6F: begin w.isel = 3'd1; w.we = 1; w.jmp = 1; w.srci = 1; end
            7'h67: begin w.we = 1; w.jmp = 1; w.srci = 1; end
            7'h63: begin w.isel = 3'd3; w.br = 1; w.alu = br_tbl[f3]; ok = (f3 != 3'd2) && (f3 != 3'd3); end
            7'h03: begin w.we = 1; w.re = 1; w.srci = 1; ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5); end
            7'h23: begin w.isel = 3'd4; w.mwe = 1; w.srci = 1; ok = (f3 < 3'd3); end
            7'h13: begin
                w.we = 1; w.srci = 1; w.alu = alu_tbl[f3];
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) w.alu = 5'd16;
                    else ok = (f7 == 7'h00);
                end
            end
            7'h33: begin
                w.we = 1;
                if (f7 == 7'h00) w.alu = alu_tbl[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) w.alu = 5'd17;
                else if (f7 == 7'h20 && f3 == 3'd5) w.alu = 5'd16;
                else ok = 1'b0;
            end
            7'h0F: w.alu = 5'd18;
            7'h73: w.alu = 5'd2;
            default: ok = 1'b0;
        endcase
        case (w.isel)
            3'd0: w.imm = x & 32'hFFFFF000;
            3'd1: begin j21 = {x[31], x[19:12], x[20], x[30:21], 1'b0}; w.imm = 32'($signed(j21)); end
            3'd3: begin b13 = {x[31], x[7], x[30:25], x[11:8], 1'b0}; w.imm = 32'($signed(b13)); end
            3'd4: w.imm = (32'($signed(x) >>> 25) << 5) | {27'd0, x[11:7]};
            default: w.imm = 32'($signed(x) >>> 20);
        endcase
        if (!ok) begin
            w.alu = 5'd31; w.we = 0; w.re = 0; w.mwe = 0;
            w.br = 0; w.jmp = 0; w.srci = 0; w.ill = 1;
        end
        return w;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] x;
        logic [6:0]  ops [10];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
        x = $urandom;
        if ($urandom_range(7) != 0) x[6:0] = ops[$urandom_range(9)];
        if ($urandom_range(1) != 0) x[31:25] = ($urandom_range(1) != 0) ? 7'h00 : 7'h20;
        if (x[6:0] == 7'h73) x[6:0] = 7'h63;
        return x;
    endfunction

    // One clock: drive dut d, check its current state against the model, advance the model.
    task automatic step(int d, bit v, logic [31:0] x, logic [31:0] pc, bit ord, bit fl, output bit acc);
        bit exp_ir;
        @(posedge clk); #1;
        t_iv[d] = v; t_ins[d] = x; t_ipc[d] = pc; t_ord[d] = ord; t_fl[d] = fl;
        @(negedge clk);
        exp_ir = !mhalt[d] && ((d == 0) ? (mn[d] < 2) : (mn[d] == 0 || ord));
        chk("in_ready", d, t_ir[d], exp_ir);
        chk("out_valid", d, t_ov[d], mn[d] > 0);
        chk("halt", d, t_hlt[d], mhalt[d]);
        if (mn[d] > 0) chk("out_word", d, obs(d), mh[d][0]);
        if (t_ov[d] && ord) seen.push_back(t_opc[d]);
        acc = v && exp_ir;
        if (fl) mn[d] = 0;
        else begin
            if (mn[d] > 0 && ord) begin mh[d][0] = mh[d][1]; mn[d]--; end
            if (acc) begin mh[d][mn[d]] = model(x, pc); mn[d]++; end
            if (acc && x[6:0] == 7'h73) mhalt[d] = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            t_fl[d] = 0; t_iv[d] = 0; t_ord[d] = 0; t_ins[d] = '0; t_ipc[d] = '0;
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", d, t_ir[d], 0);
            chk("rst_out_valid", d, t_ov[d], 0);
            chk("rst_halt", d, t_hlt[d], 0);
            chk("rst_data", d, obs(d), '0);
            mn[d] = 0; mhalt[d] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t        tv [11];
    bit          a;
    int          k;
    logic [31:0] wv [3];

    initial begin
        for (int d = 0; d < 2; d++) begin
            t_fl[d] = 0; t_iv[d] = 0; t_ord[d] = 0; t_ins[d] = '0; t_ipc[d] = '0;
        end
        //          instr         alu    isel  imm            rd     we    mwe   br    ill   srci  chk_imm
        tv[0]  = '{32'h00500093, 5'h02, 3'd2, 32'd5,         5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[1]  = '{32'h402081B3, 5'h11, 3'd2, 32'd0,         5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{32'h602081B3, 5'h1F, 3'd2, 32'd0,         5'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[3]  = '{32'hFE000EE3, 5'h03, 3'd3, 32'hFFFFFFFC,  5'd29, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[4]  = '{32'h0020A423, 5'h02, 3'd4, 32'd8,         5'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[5]  = '{32'hFFFFFFFF, 5'h1F, 3'd2, 32'd0,         5'd31, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[6]  = '{32'h123450B7, 5'h00, 3'd0, 32'h12345000,  5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[7]  = '{32'h0080006F, 5'h02, 3'd1, 32'd8,         5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[8]  = '{32'h40335293, 5'h10, 3'd2, 32'd0,         5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[9]  = '{32'h02009093, 5'h1F, 3'd2, 32'd0,         5'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[10] = '{32'h0FF0000F, 5'h12, 3'd2, 32'd0,         5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        wv = '{32'h00500093, 32'h402081B3, 32'h0020A423};

        do_reset();

        for (int i = 0; i < 11; i++) begin
            step(0, 1, tv[i].x, 32'h1000 + 32'(i * 4), 1, 0, a);
            step(0, 0, 32'h0, 32'h0, 1, 0, a);
            chk("vec_valid", i, t_ov[0], 1);
            chk("vec_ctrl", i, {t_alu[0], t_rd[0], t_we[0], t_mwe[0], t_br[0], t_ill[0], t_srci[0]},
                {tv[i].alu, tv[i].rd, tv[i].we, tv[i].mwe, tv[i].br, tv[i].ill, tv[i].srci});
            if (tv[i].ci) chk("vec_imm", i, {t_isel[0], t_imm[0]}, {tv[i].isel, tv[i].imm});
        end

        // Stall for 3 cycles while streaming 3 words, then drain and check ordering.
        for (int d = 0; d < 2; d++) begin
            do_reset();
            seen.delete();
            k = 0;
            for (int c = 0; c < 3; c++) begin
                step(d, 1, wv[k], 32'h100 + 32'(k * 4), 0, 0, a);
                if (a) k++;
            end
            chk("stall_accepts", d, k, (d == 0) ? 2 : 1);
            for (int c = 0; c < 20 && k < 3; c++) begin
                step(d, 1, wv[k], 32'h100 + 32'(k * 4), 1, 0, a);
                if (a) k++;
            end
            for (int c = 0; c < 4; c++) step(d, 0, 32'h0, 32'h0, 1, 0, a);
            chk("drain_count", d, seen.size(), 3);
            for (int j = 0; j < 3 && j < seen.size(); j++)
                chk("drain_order", d, seen[j], 32'h100 + 32'(j * 4));
        end

        // ECALL: emitted once, halt follows, input blocked until reset.
        do_reset();
        seen.delete();
        step(0, 1, 32'h00000073, 32'h200, 1, 0, a);
        step(0, 1, 32'h00500093, 32'h204, 1, 0, a);
        chk("ecall_halt", 0, t_hlt[0], 1);
        chk("ecall_word", 0, {t_ov[0], t_alu[0], t_we[0]}, {1'b1, 5'h02, 1'b0});
        for (int c = 0; c < 3; c++) step(0, 1, 32'h00500093, 32'h204, 1, 0, a);
        chk("halt_blocks", 0, {t_ir[0], t_ov[0]}, 2'b00);
        chk("ecall_once", 0, seen.size(), 1);
        do_reset();
        step(0, 1, 32'h00000073, 32'h300, 1, 1, a);
        step(0, 0, 32'h0, 32'h0, 1, 0, a);
        chk("flushed_ecall_no_halt", 0, {t_hlt[0], t_ir[0], t_ov[0]}, 3'b010);

        // Flush with skid full, and flush racing an accept.
        do_reset();
        step(0, 1, wv[0], 32'h400, 0, 0, a);
        step(0, 1, wv[1], 32'h404, 0, 0, a);
        step(0, 1, wv[2], 32'h408, 0, 1, a);
        step(0, 0, 32'h0, 32'h0, 0, 0, a);
        chk("flush_full", 0, {t_ov[0], t_ir[0]}, 2'b01);
        step(0, 1, wv[0], 32'h500, 0, 0, a);
        step(0, 1, wv[1], 32'h504, 0, 1, a);
        step(0, 0, 32'h0, 32'h0, 1, 0, a);
        chk("flush_drops_input", 0, t_ov[0], 0);

        // Asynchronous reset while stalled with both entries held.
        step(0, 1, wv[0], 32'h600, 0, 0, a);
        step(0, 1, wv[1], 32'h604, 0, 0, a);
        step(0, 0, 32'h0, 32'h0, 0, 0, a);
        #2 rst = 1'b1;
        #1;
        chk("async_rst", 0, {t_ov[0], t_ir[0]}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        mn[0] = 0; mhalt[0] = 1'b0;

        // Random traffic against the model on both configurations.
        for (int d = 0; d < 2; d++) begin
            do_reset();
            for (int c = 0; c < 600; c++)
                step(d, $urandom_range(3) != 0, gen(), $urandom, $urandom_range(2) != 0,
                     $urandom_range(19) == 0, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
